// File: rtl/tree_node_pkg.sv
// Shared types and helpers for the tree_node_bcast_join hierarchy node.
package tree_node_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BCAST = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RED_OR  = 2'd0,
    RED_AND = 2'd1,
    RED_SUM = 2'd2
  } reduce_op_e;

  // Widest response the identity helper can describe.
  localparam int unsigned MAX_RSP_W = 64;

  // Value that leaves any operand unchanged under the given reduction.
  function automatic logic [MAX_RSP_W-1:0] reduce_identity(input reduce_op_e op,
                                                           input int unsigned width);
    logic [MAX_RSP_W-1:0] ones;
    ones = {MAX_RSP_W{1'b1}} >> (MAX_RSP_W - width);
    case (op)
      RED_OR:  reduce_identity = {MAX_RSP_W{1'b0}};
      RED_AND: reduce_identity = ones;
      RED_SUM: reduce_identity = {MAX_RSP_W{1'b0}};
      default: reduce_identity = {MAX_RSP_W{1'b0}};
    endcase
  endfunction

endpackage

// File: rtl/tree_node_reduce.sv
// Combinational fold of the accepted child responses into the accumulator.
// Every child whose take bit is set is folded in the same cycle; all three
// operators are commutative, so the fold order does not affect the result.
module tree_node_reduce
  import tree_node_pkg::*;
#(
  parameter int unsigned NUM_CHILDREN = 5,
  parameter int unsigned RSP_W        = 16,
  parameter int unsigned REDUCE_OP    = 0
) (
  input  logic [RSP_W-1:0]              acc_i,
  input  logic [NUM_CHILDREN*RSP_W-1:0] rsp_data_i,
  input  logic [NUM_CHILDREN-1:0]       take_i,
  output logic [RSP_W-1:0]              acc_o
);

  localparam reduce_op_e OP_E = reduce_op_e'(REDUCE_OP[1:0]);

  logic [RSP_W-1:0] child_s;

  // Fold each taken child response into the running accumulator value.
  always_comb begin
    acc_o   = acc_i;
    child_s = {RSP_W{1'b0}};
    for (int i = 0; i < int'(NUM_CHILDREN); i++) begin
      child_s = rsp_data_i[i*RSP_W +: RSP_W];
      if (take_i[i]) begin
        case (OP_E)
          RED_OR:  acc_o = acc_o | child_s;
          RED_AND: acc_o = acc_o & child_s;
          RED_SUM: acc_o = acc_o + child_s;
          default: acc_o = acc_o;
        endcase
      end else begin
        acc_o = acc_o;
      end
    end
  end

endmodule

// File: rtl/tree_node_bcast_join.sv
// Broadcast/join hierarchy node: one upstream request fans out to every child,
// one response per child is folded into a single upstream response.
// Optional feature macro: TREE_NODE_TIMEOUT_EN (collection timeout with error flag).
module tree_node_bcast_join
  import tree_node_pkg::*;
#(
  parameter int unsigned NUM_CHILDREN = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RSP_W        = 16,
  parameter int unsigned REDUCE_OP    = 0,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          up_req_valid,
  output logic                          up_req_ready,
  input  logic [DATA_W-1:0]             up_req_data,
  output logic [NUM_CHILDREN-1:0]       dn_req_valid,
  input  logic [NUM_CHILDREN-1:0]       dn_req_ready,
  output logic [DATA_W-1:0]             dn_req_data,
  input  logic [NUM_CHILDREN-1:0]       dn_rsp_valid,
  input  logic [NUM_CHILDREN*RSP_W-1:0] dn_rsp_data,
  output logic                          up_rsp_valid,
  input  logic                          up_rsp_ready,
  output logic [RSP_W-1:0]              up_rsp_data,
  output logic [NUM_CHILDREN-1:0]       up_rsp_mask,
  output logic                          up_rsp_err,
  output logic                          busy
);

  localparam logic [NUM_CHILDREN-1:0] ALL_ONES  = {NUM_CHILDREN{1'b1}};
  localparam reduce_op_e              OP_E      = reduce_op_e'(REDUCE_OP[1:0]);
  localparam logic [RSP_W-1:0]        ACC_IDENT = RSP_W'(reduce_identity(OP_E, RSP_W));

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [NUM_CHILDREN-1:0] acc_mask_q, acc_mask_d;
  logic [NUM_CHILDREN-1:0] rsp_mask_q, rsp_mask_d;
  logic [RSP_W-1:0]        acc_q, acc_d;

  logic                    collect_s;
  logic [NUM_CHILDREN-1:0] hs_s;
  logic [NUM_CHILDREN-1:0] acc_mask_now_s;
  logic [NUM_CHILDREN-1:0] take_s;
  logic [NUM_CHILDREN-1:0] rsp_mask_now_s;
  logic [RSP_W-1:0]        fold_s;
  logic                    done_s;
  logic                    timeout_s;

  // Qualify this cycle's request handshakes and acceptable responses; a child
  // handshaking this cycle may already have its response accepted.
  always_comb begin
    collect_s      = (state_q == BCAST) || (state_q == WAIT);
    hs_s           = (state_q == BCAST) ? (dn_req_ready & ~acc_mask_q) : {NUM_CHILDREN{1'b0}};
    acc_mask_now_s = acc_mask_q | hs_s;
    take_s         = collect_s ? (dn_rsp_valid & acc_mask_now_s & ~rsp_mask_q)
                               : {NUM_CHILDREN{1'b0}};
    rsp_mask_now_s = rsp_mask_q | take_s;
    done_s         = collect_s && (rsp_mask_now_s == ALL_ONES);
  end

  tree_node_reduce #(
    .NUM_CHILDREN (NUM_CHILDREN),
    .RSP_W        (RSP_W),
    .REDUCE_OP    (REDUCE_OP)
  ) u_reduce (
    .acc_i      (acc_q),
    .rsp_data_i (dn_rsp_data),
    .take_i     (take_s),
    .acc_o      (fold_s)
  );

`ifdef TREE_NODE_TIMEOUT_EN
  localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;

  // Count cycles spent collecting; the TIMEOUT_CYC-th such cycle ends the
  // transaction unless it also completes it.
  always_comb begin
    timer_d   = timer_q;
    err_d     = err_q;
    timeout_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (up_req_valid) begin
          timer_d = {TMR_W{1'b0}};
          err_d   = 1'b0;
        end else begin
          timer_d = timer_q;
        end
      end
      BCAST, WAIT: begin
        timer_d   = timer_q + TMR_W'(1);
        timeout_s = (timer_q == TMR_LAST);
        if (timeout_s && !done_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      RESP:    timer_d = timer_q;
      default: timer_d = {TMR_W{1'b0}};
    endcase
  end

  // Timer and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= {TMR_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign up_rsp_err = err_q;
`else
  // Without the timeout the node waits for every child indefinitely.
  logic unused_timeout_cyc_s;
  assign unused_timeout_cyc_s = ^TIMEOUT_CYC;
  assign timeout_s            = 1'b0;
  assign up_rsp_err           = 1'b0;
`endif

  // Next-state and datapath update for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    acc_mask_d = acc_mask_q;
    rsp_mask_d = rsp_mask_q;
    acc_d      = acc_q;
    case (state_q)
      IDLE: begin
        if (up_req_valid) begin
          state_d    = BCAST;
          data_d     = up_req_data;
          acc_mask_d = {NUM_CHILDREN{1'b0}};
          rsp_mask_d = {NUM_CHILDREN{1'b0}};
          acc_d      = ACC_IDENT;
        end else begin
          state_d = IDLE;
        end
      end
      BCAST, WAIT: begin
        acc_mask_d = acc_mask_now_s;
        rsp_mask_d = rsp_mask_now_s;
        acc_d      = fold_s;
        if (done_s) begin
          state_d = RESP;
        end else if (timeout_s) begin
          state_d = RESP;
        end else if (acc_mask_now_s == ALL_ONES) begin
          state_d = WAIT;
        end else begin
          state_d = state_q;
        end
      end
      RESP: begin
        if (up_rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= {DATA_W{1'b0}};
      acc_mask_q <= {NUM_CHILDREN{1'b0}};
      rsp_mask_q <= {NUM_CHILDREN{1'b0}};
      acc_q      <= {RSP_W{1'b0}};
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      acc_mask_q <= acc_mask_d;
      rsp_mask_q <= rsp_mask_d;
      acc_q      <= acc_d;
    end
  end

  assign up_req_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign dn_req_valid = (state_q == BCAST) ? ~acc_mask_q : {NUM_CHILDREN{1'b0}};
  assign dn_req_data  = data_q;
  assign up_rsp_valid = (state_q == RESP);
  assign up_rsp_data  = acc_q;
  assign up_rsp_mask  = rsp_mask_q;

endmodule

// File: tb/tb_tree_node_bcast_join.sv
// Self-checking bench for tree_node_bcast_join: three instances (OR, AND, SUM)
// see identical stimulus and are compared against a plan-level reference model.
module tb_tree_node_bcast_join;

  localparam int N    = 5;
  localparam int DW   = 32;
  localparam int RW   = 16;
  localparam int TO   = 16;
  localparam int NONE = -1;
  localparam int INF  = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_req_valid;
  logic [DW-1:0] up_req_data;
  logic [N-1:0]  dn_req_ready;
  logic [N-1:0]  dn_rsp_valid;
  logic [N*RW-1:0] dn_rsp_data;
  logic          up_rsp_ready;

  logic          up_req_ready_o [3];
  logic [N-1:0]  dn_req_valid_o [3];
  logic [DW-1:0] dn_req_data_o  [3];
  logic          up_rsp_valid_o [3];
  logic [RW-1:0] up_rsp_data_o  [3];
  logic [N-1:0]  up_rsp_mask_o  [3];
  logic          up_rsp_err_o   [3];
  logic          busy_o         [3];

  int vectors = 0;
  int miscompares = 0;

  // Per-child plan: cycle the child raises ready, and up to three response pulses.
  int            rdy_cyc [N];
  int            pcyc    [N][3];
  logic [RW-1:0] pdat    [N][3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    tree_node_bcast_join #(
      .NUM_CHILDREN (N),
      .DATA_W       (DW),
      .RSP_W        (RW),
      .REDUCE_OP    (k),
      .TIMEOUT_CYC  (TO)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .up_req_valid (up_req_valid),
      .up_req_ready (up_req_ready_o[k]),
      .up_req_data  (up_req_data),
      .dn_req_valid (dn_req_valid_o[k]),
      .dn_req_ready (dn_req_ready),
      .dn_req_data  (dn_req_data_o[k]),
      .dn_rsp_valid (dn_rsp_valid),
      .dn_rsp_data  (dn_rsp_data),
      .up_rsp_valid (up_rsp_valid_o[k]),
      .up_rsp_ready (up_rsp_ready),
      .up_rsp_data  (up_rsp_data_o[k]),
      .up_rsp_mask  (up_rsp_mask_o[k]),
      .up_rsp_err   (up_rsp_err_o[k]),
      .busy         (busy_o[k])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    up_req_valid = 1'b0;
    up_req_data  = '0;
    dn_req_ready = '0;
    dn_rsp_valid = '0;
    dn_rsp_data  = '0;
    up_rsp_ready = 1'b0;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < N; i++) begin
      rdy_cyc[i] = 0;
      for (int k = 0; k < 3; k++) begin
        pcyc[i][k] = NONE;
        pdat[i][k] = RW'($urandom);
      end
    end
  endtask

  // Run one transaction from the plan. abort_c > 0 asserts rst in that cycle.
  task automatic run_txn(input string name, input logic [DW-1:0] req,
                         input int hold_n, input int abort_c);
    int            hs [N];
    int            facc [N];
    logic [RW-1:0] fdat [N];
    int            c_done, end_c, last_c;
    logic          exp_err;
    logic [N-1:0]  exp_mask, dv_exp;
    logic [RW-1:0] exp_data [3];

    // Reference model: when each child handshakes, which response counts.
    c_done = 0;
    for (int i = 0; i < N; i++) begin
      hs[i]   = (rdy_cyc[i] < 1) ? 1 : rdy_cyc[i];
      facc[i] = INF;
      fdat[i] = '0;
      for (int k = 0; k < 3; k++) begin
        if (pcyc[i][k] >= hs[i] && pcyc[i][k] < facc[i]) begin
          facc[i] = pcyc[i][k];
          fdat[i] = pdat[i][k];
        end
      end
      if (facc[i] > c_done) c_done = facc[i];
    end
    end_c   = c_done;
    exp_err = 1'b0;
`ifdef TREE_NODE_TIMEOUT_EN
    if (c_done > TO) begin
      end_c   = TO;
      exp_err = 1'b1;
    end
`endif
    exp_mask    = '0;
    exp_data[0] = '0;
    exp_data[1] = '1;
    exp_data[2] = '0;
    for (int i = 0; i < N; i++) begin
      if (facc[i] <= end_c) begin
        exp_mask[i] = 1'b1;
        exp_data[0] = exp_data[0] | fdat[i];
        exp_data[1] = exp_data[1] & fdat[i];
        exp_data[2] = exp_data[2] + fdat[i];
      end
    end
    last_c = (abort_c > 0) ? abort_c : end_c;

    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk); #1;
      rst          = (abort_c > 0) && (c == abort_c);
      up_req_valid = (c == 0);
      up_req_data  = (c == 0) ? req : DW'($urandom);
      up_rsp_ready = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        dn_req_ready[i] = (c >= rdy_cyc[i]);
        dn_rsp_valid[i] = 1'b0;
        dn_rsp_data[i*RW +: RW] = RW'($urandom);
        for (int k = 2; k >= 0; k--) begin
          if (pcyc[i][k] == c) begin
            dn_rsp_valid[i] = 1'b1;
            dn_rsp_data[i*RW +: RW] = pdat[i][k];
          end
        end
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) dv_exp[i] = (c >= 1) && (c <= hs[i]);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("%s/%0d/c%0d/up_req_ready", name, k, c), 64'(up_req_ready_o[k]), 64'(c == 0));
        chk($sformatf("%s/%0d/c%0d/busy", name, k, c), 64'(busy_o[k]), 64'(c != 0));
        chk($sformatf("%s/%0d/c%0d/up_rsp_valid", name, k, c), 64'(up_rsp_valid_o[k]), 64'(0));
        chk($sformatf("%s/%0d/c%0d/dn_req_valid", name, k, c), 64'(dn_req_valid_o[k]), 64'(dv_exp));
        if (c == 1) chk($sformatf("%s/%0d/dn_req_data", name, k), 64'(dn_req_data_o[k]), 64'(req));
      end
    end

    if (abort_c > 0) begin
      @(posedge clk); #1;
      rst = 1'b0;
      drive_idle();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("%s/%0d/rst_busy", name, k), 64'(busy_o[k]), 64'(0));
        chk($sformatf("%s/%0d/rst_up_rsp_valid", name, k), 64'(up_rsp_valid_o[k]), 64'(0));
        chk($sformatf("%s/%0d/rst_up_req_ready", name, k), 64'(up_req_ready_o[k]), 64'(1));
        chk($sformatf("%s/%0d/rst_dn_req_valid", name, k), 64'(dn_req_valid_o[k]), 64'(0));
        chk($sformatf("%s/%0d/rst_mask", name, k), 64'(up_rsp_mask_o[k]), 64'(0));
        chk($sformatf("%s/%0d/rst_data", name, k), 64'(up_rsp_data_o[k]), 64'(0));
        chk($sformatf("%s/%0d/rst_dn_req_data", name, k), 64'(dn_req_data_o[k]), 64'(0));
      end
      return;
    end

    // Response phase: held for hold_n cycles, then accepted.
    for (int h = 0; h <= hold_n; h++) begin
      @(posedge clk); #1;
      rst          = 1'b0;
      up_rsp_ready = (h == hold_n);
      up_req_valid = (h == hold_n);
      up_req_data  = DW'($urandom);
      dn_req_ready = N'($urandom);
      dn_rsp_valid = N'($urandom);
      dn_rsp_data  = (N*RW)'({$urandom, $urandom, $urandom});
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("%s/%0d/h%0d/up_rsp_valid", name, k, h), 64'(up_rsp_valid_o[k]), 64'(1));
        chk($sformatf("%s/%0d/h%0d/up_rsp_data", name, k, h), 64'(up_rsp_data_o[k]), 64'(exp_data[k]));
        chk($sformatf("%s/%0d/h%0d/up_rsp_mask", name, k, h), 64'(up_rsp_mask_o[k]), 64'(exp_mask));
        chk($sformatf("%s/%0d/h%0d/up_rsp_err", name, k, h), 64'(up_rsp_err_o[k]), 64'(exp_err));
        chk($sformatf("%s/%0d/h%0d/up_req_ready", name, k, h), 64'(up_req_ready_o[k]), 64'(0));
        chk($sformatf("%s/%0d/h%0d/dn_req_valid", name, k, h), 64'(dn_req_valid_o[k]), 64'(0));
      end
    end

    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s/%0d/post_up_req_ready", name, k), 64'(up_req_ready_o[k]), 64'(1));
      chk($sformatf("%s/%0d/post_busy", name, k), 64'(busy_o[k]), 64'(0));
      chk($sformatf("%s/%0d/post_up_rsp_valid", name, k), 64'(up_rsp_valid_o[k]), 64'(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset/%0d/up_req_ready", k), 64'(up_req_ready_o[k]), 64'(1));
      chk($sformatf("reset/%0d/busy", k), 64'(busy_o[k]), 64'(0));
      chk($sformatf("reset/%0d/dn_req_valid", k), 64'(dn_req_valid_o[k]), 64'(0));
      chk($sformatf("reset/%0d/dn_req_data", k), 64'(dn_req_data_o[k]), 64'(0));
      chk($sformatf("reset/%0d/up_rsp_valid", k), 64'(up_rsp_valid_o[k]), 64'(0));
      chk($sformatf("reset/%0d/up_rsp_data", k), 64'(up_rsp_data_o[k]), 64'(0));
      chk($sformatf("reset/%0d/up_rsp_mask", k), 64'(up_rsp_mask_o[k]), 64'(0));
      chk($sformatf("reset/%0d/up_rsp_err", k), 64'(up_rsp_err_o[k]), 64'(0));
    end

    // Step 1: all ready, children respond with 1..5 together (SUM = 15).
    clear_plan();
    for (int i = 0; i < N; i++) begin
      pcyc[i][0] = 2;
      pdat[i][0] = RW'(i + 1);
    end
    run_txn("sum15", 32'h0000_00A5, 0, 0);

    // Step 2: child 3 ready late, child 0 responds twice, child 3 pulses early.
    clear_plan();
    for (int i = 0; i < N; i++) rdy_cyc[i] = 1;
    rdy_cyc[3] = 5;
    pcyc[0][0] = 2; pdat[0][0] = 16'h0011;
    pcyc[0][1] = 4; pdat[0][1] = 16'h2200;
    pcyc[1][0] = 3; pcyc[2][0] = 3; pcyc[4][0] = 3;
    pcyc[3][0] = 3; pdat[3][0] = 16'hFFFF;
    pcyc[3][1] = 6; pdat[3][1] = 16'h0400;
    run_txn("stagger", DW'($urandom), 1, 0);

    // Step 3: one child returns zero, response held off for 5 cycles.
    clear_plan();
    for (int i = 0; i < N; i++) begin
      pcyc[i][0] = 1;
      pdat[i][0] = (i == 2) ? 16'h0000 : 16'hFFFF;
    end
    run_txn("and0", DW'($urandom), 5, 0);

    // Step 4: reset in WAIT after 2 of 5 responses, then a clean transaction.
    clear_plan();
    pcyc[0][0] = 2; pcyc[1][0] = 2;
    pcyc[2][0] = 8; pcyc[3][0] = 8; pcyc[4][0] = 8;
    run_txn("abort", DW'($urandom), 0, 4);
    clear_plan();
    for (int i = 0; i < N; i++) pcyc[i][0] = 1 + i;
    run_txn("after_rst", DW'($urandom), 0, 0);

`ifdef TREE_NODE_TIMEOUT_EN
    // Step 5: child 4 silent -> timeout; last response exactly on timeout cycle.
    clear_plan();
    for (int i = 0; i < N - 1; i++) pcyc[i][0] = 3;
    run_txn("to_silent", DW'($urandom), 1, 0);
    clear_plan();
    for (int i = 0; i < N - 1; i++) pcyc[i][0] = 3;
    pcyc[4][0] = TO;
    run_txn("to_edge", DW'($urandom), 0, 0);
    clear_plan();
    for (int i = 0; i < N - 1; i++) pcyc[i][0] = 2;
    pcyc[4][0] = TO + 1;
    run_txn("to_late", DW'($urandom), 0, 0);
`endif

    // Step 6: randomized readies, duplicates and early pulses.
    for (int t = 0; t < 8; t++) begin
      clear_plan();
      for (int i = 0; i < N; i++) begin
        int hsr;
        rdy_cyc[i] = int'($urandom_range(0, 4));
        hsr        = (rdy_cyc[i] < 1) ? 1 : rdy_cyc[i];
        pcyc[i][0] = hsr + int'($urandom_range(0, 6));
        pcyc[i][1] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : NONE;
        pcyc[i][2] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : NONE;
      end
      run_txn($sformatf("rand%0d", t), DW'($urandom), int'($urandom_range(0, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tree_node_bcast_join.md
Name: tree_node_bcast_join

Overview:
- Parametrised hierarchy node: accepts one upstream request, broadcasts it to NUM_CHILDREN child ports, and collects one response per child.
- Returns a single reduced response upstream; child-port count, payload widths and reduction mode are generic.
- Instantiated recursively to build N-ary test/control trees of arbitrary fan-out and depth.

Parameters:
- NUM_CHILDREN, 5, number of child ports (1..32).
- DATA_W, 32, request payload width.
- RSP_W, 16, per-child and reduced response width.
- REDUCE_OP, 0, reduction mode: 0=OR, 1=AND, 2=SUM (modulo 2^RSP_W).
- TIMEOUT_CYC, 1024, timeout limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- up_req_valid  in  1  upstream request valid.
- up_req_ready  out  1  node can accept a request.
- up_req_data  in  DATA_W  request payload.
- dn_req_valid  out  NUM_CHILDREN  per-child request valid.
- dn_req_ready  in  NUM_CHILDREN  per-child request ready.
- dn_req_data  out  DATA_W  registered payload, shared by all children.
- dn_rsp_valid  in  NUM_CHILDREN  per-child response pulse; the node has no backpressure on this path.
- dn_rsp_data  in  NUM_CHILDREN*RSP_W  child i response at bits [i*RSP_W +: RSP_W].
- up_rsp_valid  out  1  reduced response valid.
- up_rsp_ready  in  1  upstream accepts the response.
- up_rsp_data  out  RSP_W  reduced result.
- up_rsp_mask  out  NUM_CHILDREN  children that responded.
- up_rsp_err  out  1  timeout flag.
- busy  out  1  node is not in IDLE.

Behaviour:
- Reset values:
  - State = IDLE; all masks, the accumulator and the timer = 0.
  - Outputs: dn_req_valid=0, up_rsp_valid=0, up_rsp_data=0, up_rsp_mask=0, up_rsp_err=0, busy=0, dn_req_data=0.
  - Reset taken in any state aborts the transaction immediately; no response is issued.
- FSM states: IDLE, BCAST, WAIT, RESP.
- IDLE:
  - up_req_ready=1.
  - On up_req_valid, capture data into dn_req_data, clear acc_mask and rsp_mask, load the accumulator with the reduction identity, then go to BCAST.
  - Reduction identities: OR=0, AND=all-ones, SUM=0.
- BCAST:
  - dn_req_valid[i] = ~acc_mask[i].
  - A handshake on child i sets acc_mask[i].
  - Each child's valid drops independently the cycle after its handshake.
  - When acc_mask is all-ones (including the cycle of the last handshake), go to WAIT.
  - If rsp_mask is also complete in that cycle, go directly to RESP.
- Response capture (BCAST and WAIT):
  - dn_rsp_valid[i] is accepted only if acc_mask[i] (registered or set this cycle) and ~rsp_mask[i].
  - An accepted response sets rsp_mask[i] and folds dn_rsp_data[i] into the accumulator.
  - Multiple children responding in the same cycle are all folded that cycle; the result is order-independent.
  - Responses outside BCAST/WAIT, duplicates, and pre-acceptance pulses are ignored.
- WAIT:
  - When rsp_mask is all-ones (including the cycle the last response is accepted), go to RESP.
- RESP:
  - up_rsp_valid=1, with data, mask and err held stable until up_rsp_ready.
  - On handshake, return to IDLE; up_req_ready rises the next cycle (no same-cycle re-accept).
- Latency:
  - Upstream accept to dn_req_valid: 1 cycle.
  - Last child response to up_rsp_valid: 1 cycle.
  - Minimum transaction: 3 cycles.
- SUM reduction: RSP_W-bit adder; carries out of the MSB are discarded.

Optional Feature:
- Macro: TREE_NODE_TIMEOUT_EN.
- Enabled:
  - A $clog2(TIMEOUT_CYC+1)-bit counter clears on entry to BCAST and increments in BCAST/WAIT.
  - When it reaches TIMEOUT_CYC, go to RESP with up_rsp_err=1.
  - up_rsp_mask and the accumulator carry the partial results; dn_req_valid deasserts.
  - If a completion and the timeout occur in the same cycle, completion wins (err=0).
- Disabled: no counter; up_rsp_err is tied to 0; the node waits indefinitely.

Decomposition:
- Package tree_node_pkg holds:
  - state_e (IDLE, BCAST, WAIT, RESP).
  - reduce_op_e (RED_OR, RED_AND, RED_SUM).
  - A function returning the reduction identity for a given op and width.
- Sub-module tree_node_reduce:
  - Combinational fold of the masked child-response vector into the accumulator.
  - Parameterised by NUM_CHILDREN, RSP_W and REDUCE_OP.

Test Plan:
- Setup: N=5, SUM, all dn_req_ready=1. Send req 0xA5. Children respond data 1..5 on the same cycle. Expect up_rsp_data=15, mask=5'h1F, err=0, rsp_valid 3 cycles after req accept.
- Staggered readies (child 3 ready 4 cycles late); child 0 responds twice. Expect dn_req_valid[3] held until its handshake, only the first child-0 response counted, and OR of distinct values correct.
- AND mode with one child returning 0x0000 and the others 0xFFFF. Expect result 0x0000. Hold up_rsp_ready=0 for 5 cycles: outputs stable, up_req_ready=0.
- rst asserted in WAIT after 2 of 5 responses. Next cycle: busy=0, no up_rsp_valid. A following transaction completes correctly with stale masks cleared.
- With TREE_NODE_TIMEOUT_EN, TIMEOUT_CYC=16, child 4 silent. Expect up_rsp_err=1 and mask=5'h0F at timeout. Second run with the last response on the timeout cycle: err=0.
